// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared CPU definitions used by the fetch stage: PC and instruction widths,
// the default bubble word, the fetch FSM state encoding and small PC helpers.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2
    } fetch_state_e;

    // Sequential next-instruction address; wraps modulo 2**PC_W with no flag.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return a & {{(PC_W-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with its increment / redirect mux.
// Ports:
//   clk          - clock, updates on posedge
//   rst          - asynchronous active-high reset, loads RESET_PC
//   i_inc        - advance PC by 4 (normal fetch)
//   i_load       - load word-aligned i_load_addr (redirect), wins over i_inc
//   i_load_addr  - redirect target byte address
//   o_pc         - current PC
//   o_pc4        - current PC + 4 (modular)
// -----------------------------------------------------------------------------
module pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inc,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_addr,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc4
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;

    // Next-PC select: redirect load first, then increment, otherwise hold.
    always_comb begin
        w_pc_next = r_pc;
        if (i_load) begin
            w_pc_next = word_align(i_load_addr);
        end else if (i_inc) begin
            w_pc_next = pc_plus4(r_pc);
        end else begin
            w_pc_next = r_pc;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc  = r_pc;
    assign o_pc4 = pc_plus4(r_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage: drives the instruction memory address from the PC,
// captures the returned word into the IF/ID pipeline register, and handles
// decode stalls and branch/jump redirects.
// Ports:
//   clk, rst       - clock and asynchronous active-high reset
//   stall          - hold PC and IF/ID (decode hazard)
//   redirect       - load redirect_addr into PC and insert a bubble
//   redirect_addr  - redirect byte address (low two bits ignored)
//   memread        - instruction memory read enable (off during warm-up)
//   addr           - instruction memory byte address (= PC)
//   readdata       - instruction word from memory, valid one edge after addr
//   if_id_instr    - registered instruction
//   if_id_pc4      - registered PC+4 of that instruction
//   if_id_valid    - 1 for a real fetch, 0 for a bubble
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 8'h00,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_addr,
    output logic               memread,
    output logic [PC_W-1:0]    addr,
    input  logic [INSTR_W-1:0] readdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc4,
    output logic               if_id_valid
);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic                w_active;
    logic                w_redirect;
    logic                w_fetch;
    logic [PC_W-1:0]     w_pc;
    logic [PC_W-1:0]     w_pc4;
    logic [INSTR_W-1:0]  r_instr;
    logic [PC_W-1:0]     r_pc4;
    logic                r_valid;

    // Redirect outranks stall; nothing happens while warming up.
    assign w_active   = (r_state != ST_WARMUP);
    assign w_redirect = w_active & redirect;
    assign w_fetch    = w_active & ~redirect & ~stall;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_fetch),
        .i_load      (w_redirect),
        .i_load_addr (redirect_addr),
        .o_pc        (w_pc),
        .o_pc4       (w_pc4)
    );

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WARMUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WARMUP: w_state_next = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (redirect) begin
                    w_state_next = ST_RUN;
                end else if (stall) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_WARMUP;
        endcase
    end

    // IF/ID pipeline register: bubble on redirect, capture on fetch, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= {PC_W{1'b0}};
            r_valid <= 1'b0;
        end else if (w_redirect) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= {PC_W{1'b0}};
            r_valid <= 1'b0;
        end else if (w_fetch) begin
            r_instr <= readdata;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
        end else begin
            r_instr <= r_instr;
            r_pc4   <= r_pc4;
            r_valid <= r_valid;
        end
    end

    // memread and addr are decodes of registered state only.
    assign memread     = w_active;
    assign addr        = w_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 8'h00, byte address of the first fetch after reset.
REQ-002 Parameter: NOP_INSTR, 32'h00000000, instruction word inserted as a bubble.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 stall  input  1  hold PC and IF/ID register (hazard from decode).
REQ-006 redirect  input  1  branch taken or jump resolved; load a new PC.
REQ-007 redirect_addr  input  8  byte-address target of the redirect.
REQ-008 memread  output  1  read enable to instruction memory.
REQ-009 addr  output  8  byte address to instruction memory (word = addr>>2).
REQ-010 readdata  input  32  instruction word returned by memory.
REQ-011 if_id_instr  output  32  registered fetched instruction.
REQ-012 if_id_pc4  output  8  registered PC+4 of that instruction.
REQ-013 if_id_valid  output  1  high when if_id_instr is a real fetch, low for a bubble.

Function
REQ-014 The unit SHALL contain an 8-bit PC register and a 2-bit FSM with states WARMUP, RUN, HOLD.
REQ-015 addr SHALL equal PC combinationally in every state; memread SHALL be 1 in RUN and HOLD and 0 in WARMUP.
REQ-016 WARMUP SHALL last exactly one cycle after reset release, then move to RUN; PC and IF/ID are unchanged during it.
REQ-017 Memory read data SHALL be treated as valid at the next posedge after addr changes; the clock period must exceed the memory access delay (2 time units).
REQ-018 RUN, stall=0, redirect=0: on posedge, if_id_instr<=readdata, if_id_pc4<=PC+4, if_id_valid<=1, PC<=PC+4.
REQ-019 RUN/HOLD, stall=1, redirect=0: PC and all IF/ID outputs SHALL hold; state becomes HOLD.
REQ-020 HOLD, stall=0: return to RUN; the next posedge performs a normal fetch per REQ-018 (the held PC is re-read, so no instruction is lost).
REQ-021 redirect=1 in RUN or HOLD SHALL take priority over stall: PC<=redirect_addr & 8'hFC, if_id_instr<=NOP_INSTR, if_id_valid<=0, if_id_pc4<=0, state<=RUN.
REQ-022 redirect during WARMUP SHALL be ignored.
REQ-023 PC+4 SHALL be 8-bit modular: 8'hFC+4 wraps to 8'h00 with no flag.
REQ-024 redirect_addr bits [1:0] SHALL be discarded (word alignment forced).
REQ-025 The unit SHALL have no combinational path from readdata to any output.

Reset
REQ-026 While rst=1: PC=RESET_PC, state=WARMUP, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, memread=0, addr=RESET_PC.
REQ-027 Reset asserted mid-operation (any state) SHALL apply REQ-026 immediately, without waiting for clk.

Structure
REQ-028 FSM state encodings (WARMUP=0, RUN=1, HOLD=2), the PC width (8), the instruction width (32) and the default NOP word SHALL live in a shared CPU package.
REQ-029 The PC register with its increment/redirect mux SHALL be one sub-module, pc_reg; FSM and IF/ID register stay in the top.

Verification (instruction memory preloaded mem[0..20] with the standard test program: mem[0]=32'h200f0008, mem[1]=32'hac0f0000, mem[10]=32'h03bee022, mem[11]=32'h13800009)
REQ-030 Release rst, no stall/redirect -> cycle1 memread=0; posedge2 if_id_instr=32'h200f0008, pc4=8'h04, valid=1; posedge3 instr=32'hac0f0000, pc4=8'h08.
REQ-031 stall=1 for 2 cycles at PC=8'h08 -> IF/ID holds 32'hac0f0000/8'h08, addr stays 8'h08; after release, next capture is mem[2], pc4=8'h0C.
REQ-032 redirect=1, redirect_addr=8'h2B, stall=1 same cycle -> PC=8'h28, bubble (instr=0, valid=0); next posedge instr=32'h03bee022, pc4=8'h2C.
REQ-033 Force PC=8'hFC via redirect, run one cycle -> if_id_pc4=8'h00, PC=8'h00; next capture is mem[0].
REQ-034 Assert rst asynchronously between edges while in HOLD -> outputs take REQ-026 values before the next posedge; WARMUP repeats after release.
